lbpe_psum_accumulator: RTL and testbench

//   Consumes the bit-serial partial sums produced by the LUT-based PE, one beat per weight bit.
//   Per lane: combines beats MSB-first into a signed product sum, then accumulates over
//   cfg_groups activation groups. Emits one accumulated vector per run to the output stage.

---
 rtl/lbpe_pkg.sv | 26 ++
 rtl/lbpe_psum_accumulator_if.sv | 27 ++
 rtl/lbpe_acc_lane.sv | 80 ++++++++
 rtl/lbpe_psum_accumulator.sv | 137 +++++++++++++
 tb/tb_lbpe_psum_accumulator.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbpe_pkg.sv
// Shared definitions for the LUT-based PE partial-sum accumulator.
// Contents: FSM state encoding, default datapath dimensions, signed
// saturation bounds for ACC_WIDTH and a config-legality helper.
package lbpe_pkg;

    localparam int NUM_LANES    = 4;
    localparam int PSUM_WIDTH   = 16;
    localparam int ACC_WIDTH    = 32;
    localparam int WEIGHT_WIDTH = 16;
    localparam int CNT_WIDTH    = 8;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // A run needs 1..WEIGHT_WIDTH beats per group and at least one group.
    function automatic logic cfg_legal(input logic [4:0] wbits, input logic [CNT_WIDTH-1:0] groups);
        return (wbits != 5'd0) && (int'(wbits) <= WEIGHT_WIDTH) && (groups != '0);
    endfunction

endpackage

// File: rtl/lbpe_psum_accumulator_if.sv
// Beat/result bus of the partial-sum accumulator.
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high; the producer holds valid and data stable until then.
//   in_valid/in_ready/in_psum    : bit-serial partial-sum beats, lane0 in LSBs
//   out_valid/out_ready/out_acc  : accumulated result vector, lane0 in LSBs
// Modports: master = beat producer / result consumer, slave = accumulator.
interface lbpe_psum_accumulator_if;
    import lbpe_pkg::*;

    logic                              in_valid;
    logic                              in_ready;
    logic [NUM_LANES*PSUM_WIDTH-1:0]   in_psum;
    logic                              out_valid;
    logic                              out_ready;
    logic [NUM_LANES*ACC_WIDTH-1:0]    out_acc;

    modport master (
        output in_valid, in_psum, out_ready,
        input  in_ready, out_valid, out_acc
    );

    modport slave (
        input  in_valid, in_psum, out_ready,
        output in_ready, out_valid, out_acc
    );

endinterface

// File: rtl/lbpe_acc_lane.sv
// One lane of the accumulator: folds MSB-first bit-serial partial sums into
// a signed product sum (bitacc) and adds it into the group sum.
// Config macro: PSUM_SAT_EN -- group add saturates to signed ACC_WIDTH and
// reports it on sat_hit; otherwise the add wraps and sat_hit is 0.
// Ports:
//   clk, rst  clock, async active-high reset
//   clear     zero bitacc and sum (start of a run)
//   beat      accepted beat this cycle
//   first     beat is bit 0 of a group
//   negate    bit 0 carries negative weight (wbits > 1)
//   last      beat is the last bit of a group (sum is updated)
//   psum      signed partial sum for this lane
//   sum_next  sum including the current group's bitacc (combinational)
//   sat_hit   group add saturated (combinational)
module lbpe_acc_lane
    import lbpe_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         beat,
    input  logic                         first,
    input  logic                         negate,
    input  logic                         last,
    input  logic signed [PSUM_WIDTH-1:0] psum,
    output logic signed [ACC_WIDTH-1:0]  sum_next,
    output logic                         sat_hit
);

    logic signed [ACC_WIDTH-1:0] bitacc;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH-1:0] psum_ext;
    logic signed [ACC_WIDTH-1:0] bitacc_next;

    assign psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum[PSUM_WIDTH-1]}}, psum};

    // Bitacc shift always wraps; only the group add may saturate.
    always_comb begin
        bitacc_next = '0;
        if (first) begin
            bitacc_next = negate ? -psum_ext : psum_ext;
        end else begin
            bitacc_next = (bitacc <<< 1) + psum_ext;
        end
    end

`ifdef PSUM_SAT_EN
    logic signed [ACC_WIDTH:0] wide_sum;

    always_comb begin
        wide_sum = {sum[ACC_WIDTH-1], sum} + {bitacc_next[ACC_WIDTH-1], bitacc_next};
        sum_next = wide_sum[ACC_WIDTH-1:0];
        sat_hit  = 1'b0;
        // Sign of the extra bit disagreeing with the MSB means the sum left range.
        if (wide_sum[ACC_WIDTH] != wide_sum[ACC_WIDTH-1]) begin
            sat_hit  = 1'b1;
            sum_next = wide_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign sum_next = sum + bitacc_next;
    assign sat_hit  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitacc <= '0;
            sum    <= '0;
        end else if (clear) begin
            bitacc <= '0;
            sum    <= '0;
        end else if (beat) begin
            bitacc <= bitacc_next;
            if (last) begin
                sum <= sum_next;
            end
        end
    end

endmodule

// File: rtl/lbpe_psum_accumulator.sv
// Partial-sum accumulator for the LUT-based PE. Collects cfg_wbits beats per
// group over cfg_groups groups, then presents one accumulated vector.
// Config macro: PSUM_SAT_EN -- saturating group add with sticky ovf flag.
// Ports:
//   clk, rst              clock, async active-high reset
//   cfg_start             start pulse, cfg_wbits/cfg_groups sampled with it
//   cfg_wbits, cfg_groups run configuration
//   bus (slave)           beat input / result output handshake bus
//   busy                  high while a run is in progress or result pending
//   err_cfg               one-cycle pulse after an illegal cfg_start
//   ovf                   sticky saturation flag (0 without PSUM_SAT_EN)
//   dbg_state             current FSM state
module lbpe_psum_accumulator
    import lbpe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [4:0]           cfg_wbits,
    input  logic [CNT_WIDTH-1:0] cfg_groups,
    lbpe_psum_accumulator_if.slave bus,
    output logic                 busy,
    output logic                 err_cfg,
    output logic                 ovf,
    output state_t               dbg_state
);

    state_t                         state;
    logic [4:0]                     wbits_q;
    logic [CNT_WIDTH-1:0]           groups_q;
    logic [4:0]                     bit_cnt;
    logic [CNT_WIDTH-1:0]           grp_cnt;
    logic                           in_ready_q;
    logic                           out_valid_q;
    logic [NUM_LANES*ACC_WIDTH-1:0] out_acc_q;

    logic                           start_ok;
    logic                           beat;
    logic                           first_bit;
    logic                           last_bit;
    logic                           last_grp;
    logic [NUM_LANES*ACC_WIDTH-1:0] lane_sum;
    logic [NUM_LANES-1:0]           lane_sat;

    assign start_ok  = (state == ST_IDLE) && cfg_start && cfg_legal(cfg_wbits, cfg_groups);
    // in_ready_q is only ever high in ACCUM, so it also qualifies the state.
    assign beat      = bus.in_valid && in_ready_q;
    assign first_bit = (bit_cnt == 5'd0);
    assign last_bit  = (bit_cnt == wbits_q - 5'd1);
    assign last_grp  = (grp_cnt == groups_q - CNT_WIDTH'(1));

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        lbpe_acc_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (start_ok),
            .beat     (beat),
            .first    (first_bit),
            .negate   (wbits_q != 5'd1),
            .last     (last_bit),
            .psum     (bus.in_psum[l*PSUM_WIDTH +: PSUM_WIDTH]),
            .sum_next (lane_sum[l*ACC_WIDTH +: ACC_WIDTH]),
            .sat_hit  (lane_sat[l])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            wbits_q     <= '0;
            groups_q    <= '0;
            bit_cnt     <= '0;
            grp_cnt     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            busy        <= 1'b0;
            err_cfg     <= 1'b0;
            ovf         <= 1'b0;
        end else begin
            err_cfg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cfg_start) begin
                        if (start_ok) begin
                            wbits_q    <= cfg_wbits;
                            groups_q   <= cfg_groups;
                            bit_cnt    <= '0;
                            grp_cnt    <= '0;
                            ovf        <= 1'b0;
                            in_ready_q <= 1'b1;
                            busy       <= 1'b1;
                            state      <= ST_ACCUM;
                        end else begin
                            err_cfg <= 1'b1;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (beat) begin
                        if (last_bit) begin
                            bit_cnt <= '0;
                            if (|lane_sat) begin
                                ovf <= 1'b1;
                            end
                            if (last_grp) begin
                                grp_cnt     <= '0;
                                out_acc_q   <= lane_sum;
                                out_valid_q <= 1'b1;
                                in_ready_q  <= 1'b0;
                                state       <= ST_DONE;
                            end else begin
                                grp_cnt <= grp_cnt + CNT_WIDTH'(1);
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        busy        <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_lbpe_psum_accumulator.sv
// Directed bench for lbpe_psum_accumulator. Expected result vectors come
// from a weighted-sum model of each run and are queued when the run's beats
// are issued, then popped when the DUT presents out_valid.
module tb_lbpe_psum_accumulator;
    import lbpe_pkg::*;

    localparam int W = NUM_LANES * ACC_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 cfg_start = 1'b0;
    logic [4:0]           cfg_wbits = '0;
    logic [CNT_WIDTH-1:0] cfg_groups = '0;
    logic                 busy, err_cfg, ovf;
    state_t               dbg_state;

    lbpe_psum_accumulator_if bus ();

    lbpe_psum_accumulator dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_start  (cfg_start),
        .cfg_wbits  (cfg_wbits),
        .cfg_groups (cfg_groups),
        .bus        (bus),
        .busy       (busy),
        .err_cfg    (err_cfg),
        .ovf        (ovf),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0]                  exp_q[$];
    logic                          exp_ovf_q[$];
    logic [NUM_LANES*PSUM_WIDTH-1:0] beat_q[$];
    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] last_acc;

    task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NUM_LANES*PSUM_WIDTH-1:0] mk(input int lane, input int val);
        logic [NUM_LANES*PSUM_WIDTH-1:0] v;
        logic [PSUM_WIDTH-1:0] s;
        v = '0;
        s = PSUM_WIDTH'(val);
        v[lane*PSUM_WIDTH +: PSUM_WIDTH] = s;
        return v;
    endfunction

    // Result = sum over groups of sum_i psum_i * weight_i, weight of bit 0 is
    // -2^(wbits-1) (or +1 when wbits==1), others 2^(wbits-1-i).
    function automatic void model(input int wbits, input int groups,
                                  output logic [W-1:0] res, output logic o);
        res = '0;
        o   = 1'b0;
        for (int lane = 0; lane < NUM_LANES; lane++) begin
            longint sum;
            sum = 0;
            for (int g = 0; g < groups; g++) begin
                longint ba;
                ba = 0;
                for (int i = 0; i < wbits; i++) begin
                    logic [NUM_LANES*PSUM_WIDTH-1:0] v;
                    logic [PSUM_WIDTH-1:0] ps;
                    longint p, w;
                    v  = beat_q[g*wbits + i];
                    ps = v[lane*PSUM_WIDTH +: PSUM_WIDTH];
                    p  = longint'(signed'(ps));
                    w  = (i == 0 && wbits > 1) ? -(longint'(1) << (wbits-1)) : (longint'(1) << (wbits-1-i));
                    ba += p * w;
                end
                ba = longint'(signed'(ba[31:0]));
                sum += ba;
`ifdef PSUM_SAT_EN
                if (sum > 64'sd2147483647) begin
                    sum = 64'sd2147483647;
                    o = 1'b1;
                end else if (sum < -64'sd2147483648) begin
                    sum = -64'sd2147483648;
                    o = 1'b1;
                end
`else
                sum = longint'(signed'(sum[31:0]));
`endif
            end
            res[lane*ACC_WIDTH +: ACC_WIDTH] = sum[31:0];
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start(input int wbits, input int groups);
        cfg_start  = 1'b1;
        cfg_wbits  = 5'(wbits);
        cfg_groups = CNT_WIDTH'(groups);
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic send_beat(input logic [NUM_LANES*PSUM_WIDTH-1:0] v);
        int n;
        bus.in_valid = 1'b1;
        bus.in_psum  = v;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("in_ready_wait", W'(bus.in_ready), W'(1));
        tick();
        bus.in_valid = 1'b0;
        bus.in_psum  = '0;
    endtask

    // Model the queued beats, start a run and stream them.
    task automatic run(input int wbits, input int groups, input bit gaps);
        logic [W-1:0] e;
        logic         o;
        model(wbits, groups, e, o);
        exp_q.push_back(e);
        exp_ovf_q.push_back(o);
        start(wbits, groups);
        check("busy_after_start", W'(busy), W'(1));
        for (int b = 0; b < wbits * groups; b++) begin
            send_beat(beat_q.pop_front());
            if (gaps && b != wbits * groups - 1) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        check("out_valid_latency", W'(bus.out_valid), W'(1));
    endtask

    task automatic collect();
        int n;
        logic [W-1:0] e;
        logic         o;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("out_valid_wait", W'(bus.out_valid), W'(1));
        if (exp_q.size() == 0) begin
            check("exp_q_nonempty", W'(0), W'(1));
        end else begin
            e = exp_q.pop_front();
            o = exp_ovf_q.pop_front();
            last_acc = bus.out_acc;
            check("out_acc", bus.out_acc, e);
            check("ovf", W'(ovf), W'(o));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("out_valid_cleared", W'(bus.out_valid), W'(0));
        check("busy_cleared", W'(busy), W'(0));
    endtask

    task automatic illegal_cfg(input string tag, input int wbits, input int groups);
        start(wbits, groups);
        check({tag, "_err"}, W'(err_cfg), W'(1));
        check({tag, "_busy"}, W'(busy), W'(0));
        tick();
        check({tag, "_err_pulse"}, W'(err_cfg), W'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [W-1:0] held;
        int wb, gr;
        bus.in_valid  = 1'b0;
        bus.in_psum   = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", W'(bus.out_valid), W'(0));
        check("rst_out_acc", bus.out_acc, W'(0));
        check("rst_in_ready", W'(bus.in_ready), W'(0));
        check("rst_busy_err_ovf", W'({busy, err_cfg, ovf}), W'(0));
        check("rst_state", W'(dbg_state), W'(ST_IDLE));
        rst = 1'b0;
        tick();

        // wbits=4, groups=1: 3,1,0,2 -> -18
        foreach (beat_q[i]) ;
        beat_q = {mk(0, 3), mk(0, 1), mk(0, 0), mk(0, 2)};
        run(4, 1, 1'b0);
        collect();
        check("t1_lane0", W'(last_acc[31:0]), W'(32'hFFFF_FFEE));
        check("t1_others", W'(last_acc[W-1:32]), W'(0));

        // wbits=4, groups=2, same beats twice -> -36
        beat_q = {mk(0, 3), mk(0, 1), mk(0, 0), mk(0, 2), mk(0, 3), mk(0, 1), mk(0, 0), mk(0, 2)};
        run(4, 2, 1'b0);
        collect();
        check("t2_lane0", W'(last_acc[31:0]), W'(32'hFFFF_FFDC));

        // wbits=1, groups=3, lane1 5,-2,7 with idle gaps -> 10
        beat_q = {mk(1, 5), mk(1, -2), mk(1, 7)};
        run(1, 3, 1'b1);
        collect();
        check("t3_lane1", W'(last_acc[63:32]), W'(10));

        // Back-pressure: result held 5 cycles, cfg_start ignored in DONE
        for (int i = 0; i < 4; i++) beat_q.push_back(NUM_LANES*PSUM_WIDTH'({$urandom, $urandom}));
        run(4, 1, 1'b0);
        held = bus.out_acc;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                start(4, 1);
            end else begin
                tick();
            end
            check("hold_out_valid", W'(bus.out_valid), W'(1));
            check("hold_out_acc", bus.out_acc, held);
            check("hold_in_ready", W'(bus.in_ready), W'(0));
            check("hold_state", W'({busy, dbg_state}), W'({1'b1, ST_DONE}));
        end
        collect();

        // Illegal configurations
        illegal_cfg("cfg_wbits0", 0, 1);
        illegal_cfg("cfg_groups0", 4, 0);
        illegal_cfg("cfg_wbits17", 17, 1);

        // Reset mid-run after 2 beats
        start(4, 1);
        send_beat(mk(0, 9));
        send_beat(mk(2, -4));
        rst = 1'b1;
        #1;
        check("midrst_out", W'({bus.out_valid, bus.in_ready, busy, err_cfg, ovf}), W'(0));
        check("midrst_acc", bus.out_acc, W'(0));
        check("midrst_state", W'(dbg_state), W'(ST_IDLE));
        tick();
        rst = 1'b0;
        tick();
        beat_q = {mk(0, 3), mk(0, 1), mk(0, 0), mk(0, 2)};
        run(4, 1, 1'b0);
        collect();
        check("midrst_rerun_lane0", W'(last_acc[31:0]), W'(32'hFFFF_FFEE));

        // Overflow: wbits=16, groups=4, beats 0 then 0x7FFF x15 on lane0
        for (int g = 0; g < 4; g++) begin
            beat_q.push_back(mk(0, 0));
            for (int i = 0; i < 15; i++) beat_q.push_back(mk(0, 32'h7FFF));
        end
        run(16, 4, 1'b0);
        collect();
`ifdef PSUM_SAT_EN
        check("ovf_lane0_sat", W'(last_acc[31:0]), W'(32'h7FFF_FFFF));
`else
        check("ovf_lane0_wrap", W'(last_acc[31:0]), W'(32'hFFFC_0004));
`endif

        // Random runs across all lanes
        for (int r = 0; r < 3; r++) begin
            wb = $urandom_range(1, 16);
            gr = $urandom_range(1, 3);
            for (int b = 0; b < wb * gr; b++) beat_q.push_back(NUM_LANES*PSUM_WIDTH'({$urandom, $urandom}));
            run(wb, gr, r[0]);
            collect();
        end

        check("exp_q_drained", W'(exp_q.size()), W'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
